// File: rtl/retire_trace_pkg.sv
// Shared widths, the packed retirement record, and the rules that turn raw
// tap signals into a record.
package retire_trace_pkg;

    localparam int XLEN      = 32;
    localparam int PRIV_W    = 3;
    localparam int REG_W     = 5;
    localparam int SEQ_MAX_W = 32;

    typedef struct packed {
        logic [SEQ_MAX_W-1:0] seq;
        logic                 gap;
        logic                 excpt;
        logic [PRIV_W-1:0]    priv_mode;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      inst;
        logic                 wr_valid;
        logic [REG_W-1:0]     wrdst;
        logic [XLEN-1:0]      wrdata;
        logic [XLEN-1:0]      timer;
    } retire_rec_t;

    // Writes to x0 and writes on an excepting instruction are not architectural.
    function automatic retire_rec_t make_rec(
        input logic [SEQ_MAX_W-1:0] seq,
        input logic                 gap,
        input logic                 excpt,
        input logic [PRIV_W-1:0]    priv_mode,
        input logic [XLEN-1:0]      pc,
        input logic [XLEN-1:0]      inst,
        input logic                 wrenx,
        input logic [REG_W-1:0]     wrdst,
        input logic [XLEN-1:0]      wrdata,
        input logic [XLEN-1:0]      timer
    );
        retire_rec_t r;
        logic        wv;
        wv          = wrenx & (wrdst != '0) & ~excpt;
        r.seq       = seq;
        r.gap       = gap;
        r.excpt     = excpt;
        r.priv_mode = priv_mode;
        r.pc        = pc;
        r.inst      = inst;
        r.wr_valid  = wv;
        r.wrdst     = wv ? wrdst : '0;
        r.wrdata    = wv ? wrdata : '0;
        r.timer     = timer;
        return r;
    endfunction

endpackage

// File: rtl/retire_trace_fifo_ring_buf.sv
// Circular register-array buffer with push/pop, occupancy and a
// combinational head read.
module trace_ring_buf #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (level <= LW'(DEPTH));
            assert (!(pop && level == '0));
        end
    end

endmodule

// File: rtl/retire_trace_fifo.sv
// Captures retirement trace events into sequence-numbered records, buffers
// them, and accounts for records dropped under backpressure.
module retire_trace_fifo
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic                     in_valid,
    input  logic                     in_excpt,
    input  logic [PRIV_W-1:0]        in_priv_mode,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    input  logic [REG_W-1:0]         in_wrdst,
    input  logic [XLEN-1:0]          in_wrdata,
    input  logic                     in_wrenx,
    input  logic [XLEN-1:0]          in_timer,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEQ_W-1:0]         out_seq,
    output logic                     out_gap,
    output logic                     out_excpt,
    output logic [PRIV_W-1:0]        out_priv_mode,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic                     out_wr_valid,
    output logic [REG_W-1:0]         out_wrdst,
    output logic [XLEN-1:0]          out_wrdata,
    output logic [XLEN-1:0]          out_timer,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              drop_count
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic              cap_event;
    logic              push;
    logic              pop;
    logic              drop;
    logic [SEQ_W-1:0]  seq;
    logic              pending_gap;
    retire_rec_t       new_rec;
    retire_rec_t       head;
    retire_rec_t       shown;

    assign cap_event = capture_en & (in_valid | in_excpt);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A full buffer being drained this cycle still has room for the new record.
    assign push      = cap_event & ((level < FULL) | pop);
    assign drop      = cap_event & ~push;

    assign new_rec = make_rec(SEQ_MAX_W'(seq), pending_gap, in_excpt, in_priv_mode,
                              in_pc, in_inst, in_wrenx, in_wrdst, in_wrdata, in_timer);

    always_ff @(posedge clock) begin
        if (!reset) begin
            seq         <= '0;
            pending_gap <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (cap_event) seq <= seq + SEQ_W'(1);
            if (drop) pending_gap <= 1'b1;
            else if (push) pending_gap <= 1'b0;
            if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
        end
    end

    trace_ring_buf #(
        .T     (retire_rec_t),
        .DEPTH (DEPTH)
    ) u_ring (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (new_rec),
        .head  (head),
        .level (level)
    );

    // Stale storage never leaks onto the output while the buffer is empty.
    assign shown         = out_valid ? head : '0;
    assign out_seq       = shown.seq[SEQ_W-1:0];
    assign out_gap       = shown.gap;
    assign out_excpt     = shown.excpt;
    assign out_priv_mode = shown.priv_mode;
    assign out_pc        = shown.pc;
    assign out_inst      = shown.inst;
    assign out_wr_valid  = shown.wr_valid;
    assign out_wrdst     = shown.wrdst;
    assign out_wrdata    = shown.wrdata;
    assign out_timer     = shown.timer;

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(in_valid && in_excpt))
                else $warning("in_valid and in_excpt asserted together");
        end
    end

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Bench for retire_trace_fifo: a reference model feeds a scoreboard queue,
// plus a field-rule vector table and directed backpressure/reset sequences.
module tb_retire_trace_fifo;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        capture_en = 1'b0, in_valid = 1'b0, in_excpt = 1'b0, in_wrenx = 1'b0;
    logic [2:0]  in_priv_mode = '0;
    logic [31:0] in_pc = '0, in_inst = '0, in_wrdata = '0, in_timer = '0;
    logic [4:0]  in_wrdst = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_gap, out_excpt, out_wr_valid;
    logic [31:0] out_seq, out_pc, out_inst, out_wrdata, out_timer, drop_count;
    logic [2:0]  out_priv_mode;
    logic [4:0]  out_wrdst;
    logic [4:0]  level;

    retire_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
        .clock(clock), .reset(reset), .capture_en(capture_en),
        .in_valid(in_valid), .in_excpt(in_excpt), .in_priv_mode(in_priv_mode),
        .in_pc(in_pc), .in_inst(in_inst), .in_wrdst(in_wrdst), .in_wrdata(in_wrdata),
        .in_wrenx(in_wrenx), .in_timer(in_timer),
        .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq), .out_gap(out_gap),
        .out_excpt(out_excpt), .out_priv_mode(out_priv_mode), .out_pc(out_pc),
        .out_inst(out_inst), .out_wr_valid(out_wr_valid), .out_wrdst(out_wrdst),
        .out_wrdata(out_wrdata), .out_timer(out_timer), .level(level),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] seq;
        logic        gap;
        logic        excpt;
        logic [2:0]  pm;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wrv;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [31:0] tm;
    } exp_t;

    typedef struct {
        logic        excpt;
        logic [2:0]  pm;
        logic [31:0] pc;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        we;
        logic        e_wrv;
        logic [4:0]  e_wd;
        logic [31:0] e_wdata;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_level = 0;
    logic [31:0] m_seq = '0;
    logic        m_gap = 1'b0;
    logic [31:0] m_drop = '0;
    logic [31:0] cyc = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, check head vs scoreboard, advance the model.
    task automatic cycle(input logic ce, input logic v, input logic ex, input logic [2:0] pm,
                         input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] wd,
                         input logic [31:0] wdata, input logic we, input logic rdy);
        exp_t e;
        logic ev, pop_m, push_m;
        capture_en = ce; in_valid = v; in_excpt = ex; in_priv_mode = pm;
        in_pc = pc; in_inst = inst; in_wrdst = wd; in_wrdata = wdata;
        in_wrenx = we; in_timer = cyc; out_ready = rdy;
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_level != 0));
        if (out_valid && q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else if (out_valid) begin
            chk("out_seq", 64'(out_seq), 64'(q[0].seq));
            chk("out_flags", 64'({out_gap, out_excpt, out_priv_mode, out_wr_valid, out_wrdst}),
                64'({q[0].gap, q[0].excpt, q[0].pm, q[0].wrv, q[0].wd}));
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            chk("out_inst_data", {out_inst, out_wrdata}, {q[0].inst, q[0].wdata});
            chk("out_timer", 64'(out_timer), 64'(q[0].tm));
        end else begin
            chk("idle_zero", 64'(|{out_seq, out_gap, out_excpt, out_priv_mode, out_pc, out_inst,
                                   out_wr_valid, out_wrdst, out_wrdata, out_timer}), 64'(0));
        end
        pop_m = (m_level != 0) && rdy;
        if (pop_m && q.size() > 0) void'(q.pop_front());
        ev = ce && (v || ex);
        push_m = ev && (m_level < DEPTH || pop_m);
        if (push_m) begin
            e.seq = m_seq; e.gap = m_gap; e.excpt = ex; e.pm = pm; e.pc = pc; e.inst = inst;
            e.wrv = we && (wd != 5'd0) && !ex;
            e.wd = e.wrv ? wd : 5'd0;
            e.wdata = e.wrv ? wdata : 32'd0;
            e.tm = cyc;
            q.push_back(e);
            m_gap = 1'b0;
        end else if (ev) begin
            m_gap = 1'b1;
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
        end
        if (ev) m_seq = m_seq + 1;
        m_level = m_level + int'(push_m) - int'(pop_m);
        @(posedge clock);
        @(negedge clock);
        cyc = cyc + 1;
        chk("level", 64'(level), 64'(m_level));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, rdy);
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] wd, input logic [31:0] wdata,
                          input logic rdy);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, pc, pc ^ 32'h0000_0013, wd, wdata, 1'b1, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        capture_en = 1'b0; in_valid = 1'b0; in_excpt = 1'b0; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_level = 0; m_seq = '0; m_gap = 1'b0; m_drop = '0;
        q.delete();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_drop", 64'(drop_count), 64'(0));
        chk("rst_fields_zero", 64'(|{out_seq, out_gap, out_excpt, out_priv_mode, out_pc, out_inst,
                                     out_wr_valid, out_wrdst, out_wrdata, out_timer}), 64'(0));
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b0, 3'd0, 32'h0000_1000, 5'd5,  32'h0000_1234, 1'b1, 1'b1, 5'd5,  32'h0000_1234};
        tbl[1] = '{1'b0, 3'd1, 32'h0000_1004, 5'd0,  32'h0000_DEAD, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[2] = '{1'b0, 3'd0, 32'h0000_1008, 5'd7,  32'h0000_BEEF, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[3] = '{1'b1, 3'd3, 32'h8000_0100, 5'd9,  32'h0000_0055, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[4] = '{1'b0, 3'd0, 32'h0000_100C, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF};

        @(negedge clock);
        do_reset();

        // Three back-to-back retirements drained as they arrive.
        retire(32'h8000_0000, 5'd5, 32'h11, 1'b1);
        chk("t1_first_seq", 64'(out_seq), 64'(0));
        chk("t1_first_pc", 64'(out_pc), 64'h8000_0000);
        retire(32'h8000_0004, 5'd5, 32'h22, 1'b1);
        retire(32'h8000_0008, 5'd5, 32'h33, 1'b1);
        idle(1'b1);
        chk("t1_level_empty", 64'(level), 64'(0));

        // Field rules, one record at a time held at the head.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, !tbl[i].excpt, tbl[i].excpt, tbl[i].pm, tbl[i].pc, 32'h0000_0073,
                  tbl[i].wd, tbl[i].wdata, tbl[i].we, 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("vec%0d_wr", i), 64'({out_wr_valid, out_wrdst, out_wrdata}),
                64'({tbl[i].e_wrv, tbl[i].e_wd, tbl[i].e_wdata}));
            chk($sformatf("vec%0d_excpt_pm", i), 64'({out_excpt, out_priv_mode}),
                64'({tbl[i].excpt, tbl[i].pm}));
            chk($sformatf("vec%0d_seq", i), 64'(out_seq), 64'(3 + i));
            idle(1'b1);
        end

        // Gated event consumes no seq; the next captured one continues at 8.
        cycle(1'b0, 1'b1, 1'b0, 3'd0, 32'h2000, 32'h13, 5'd1, 32'h1, 1'b1, 1'b1);
        chk("gated_no_record", 64'(out_valid), 64'(0));
        retire(32'h2004, 5'd2, 32'h2, 1'b0);
        chk("gated_seq_kept", 64'(out_seq), 64'(8));
        idle(1'b1);

        // Overflow: 16 stored, 4 dropped, then a push into a full-but-draining buffer.
        do_reset();
        for (int i = 0; i < 20; i++) retire(32'h9000_0000 + 32'(i * 4), 5'd3, 32'(i), 1'b0);
        chk("ovf_level", 64'(level), 64'(16));
        chk("ovf_drops", 64'(drop_count), 64'(4));
        retire(32'h9000_1000, 5'd3, 32'h77, 1'b1);
        chk("full_push_level", 64'(level), 64'(16));
        chk("full_push_drops", 64'(drop_count), 64'(4));
        for (int i = 0; i < 15; i++) idle(1'b1);
        chk("gap_rec_seq", 64'(out_seq), 64'(20));
        chk("gap_rec_gap", 64'(out_gap), 64'(1));
        idle(1'b1);
        chk("ovf_drained", 64'(level), 64'(0));

        // Reset in the middle of a drain wipes everything, drop_count included.
        for (int i = 0; i < 5; i++) retire(32'hA000_0000 + 32'(i * 4), 5'd4, 32'(i), 1'b0);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        idle(1'b1);
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        retire(32'hB000_0000, 5'd6, 32'h66, 1'b0);
        chk("post_rst_seq", 64'(out_seq), 64'(0));
        chk("post_rst_gap", 64'(out_gap), 64'(0));
        idle(1'b1);
        chk("sb_empty", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Consumes the per-retirement trace signals that the core data tap exports (valid, excpt, priv_mode, pc, inst, wrdst, wrdata, wrenx, timer).
- Packs them into sequence-numbered records and buffers them in a circular FIFO.
- Streams the records out on a valid/ready interface to the bench logger and ISS comparator.
- Accounts for records lost to backpressure, so gaps in the trace can be detected downstream.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SEQ_W, 32, sequence-number width; wraps modulo 2^SEQ_W.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low: asserted when 0, sampled on the rising edge of clock.
- capture_en  in  1  capture gate; 0 means nothing is captured and seq does not advance.
- in_valid  in  1  instruction retired this cycle.
- in_excpt  in  1  exception taken this cycle.
- in_priv_mode  in  3  privilege mode.
- in_pc  in  32  retired PC.
- in_inst  in  32  instruction bits.
- in_wrdst  in  5  destination register index.
- in_wrdata  in  32  writeback data.
- in_wrenx  in  1  integer register-file write enable.
- in_timer  in  32  cycle timer.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_seq  out  SEQ_W  record sequence number.
- out_gap  out  1  at least one record was dropped immediately before this one.
- out_excpt  out  1  exception record.
- out_priv_mode  out  3  privilege mode.
- out_pc  out  32  PC.
- out_inst  out  32  instruction bits.
- out_wr_valid  out  1  architectural integer write occurred.
- out_wrdst  out  5  destination register.
- out_wrdata  out  32  write data.
- out_timer  out  32  timer value.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_count  out  32  saturating count of dropped records.

Behaviour:
- Reset (reset==0 at an edge):
  - Clears wr_ptr, rd_ptr, level, seq counter, pending_gap and drop_count.
  - out_valid=0 and every out_* data field reads 0.
  - Reset mid-stream discards all buffered records; no partial record survives.
- Capture event: capture_en & (in_valid | in_excpt). Each event consumes the current seq value, and seq then increments by 1, wrapping. Dropped events also consume a seq value, so gaps appear as seq discontinuities.
- Record field rules:
  - wr_valid = in_wrenx & (in_wrdst != 0) & ~in_excpt.
  - wrdst and wrdata are zeroed when wr_valid=0.
  - excpt = in_excpt.
  - All other fields pass through unmodified.
- pop = out_valid & out_ready.
- push = event & (level < DEPTH | pop). A full FIFO popped in the same cycle still accepts the push.
- Drop = event & ~push:
  - drop_count increments, saturating at 0xFFFF_FFFF.
  - pending_gap is set.
- When a push occurs:
  - The record's gap bit = pending_gap.
  - pending_gap clears on that push, unless the same cycle also drops (impossible: one event per cycle).
- Pointers: wr_ptr and rd_ptr are log2(DEPTH)-bit and wrap naturally.
- level update: level += push - pop. Simultaneous push and pop leaves level unchanged.
- Output timing:
  - out_* are driven combinationally from the head entry: out_valid = (level != 0).
  - A record pushed at edge N on an empty FIFO is visible from edge N onward (one-cycle latency from the input sample).
  - While out_valid & ~out_ready, all out_* are held stable.
  - out_* data reads 0 when out_valid=0 (masked, not stale).
- capture_en deassertion does not flush; buffered records drain normally.
- Assertions, simulation-only:
  - level never exceeds DEPTH.
  - No pop when empty.
  - in_valid and in_excpt are not both 1 in the same cycle (flagged, not fatal); if both occur, a single excpt record is captured.

Decomposition:
- Package retire_trace_pkg:
  - Width constants XLEN=32, PRIV_W=3, REG_W=5.
  - Packed struct retire_rec_t with fields seq, gap, excpt, priv_mode, pc, inst, wr_valid, wrdst, wrdata, timer.
  - Helper function make_rec() applying the field rules above.
- One sub-module, trace_ring_buf (parameterised T, DEPTH):
  - Register-array storage, pointer and level logic.
  - Push/pop ports, head output.
- retire_trace_fifo owns event qualification, the seq counter, the gap/drop accounting and the output masking.

Test Plan:
1. Reset, then 3 consecutive in_valid events (pc 0x8000_0000/04/08, wrenx=1, wrdst=5, wrdata=0x11/22/33) with out_ready=1 -> records emitted in order: seq 0,1,2, wr_valid=1, gap=0; level returns to 0; drop_count=0.
2. Write to x0 (wrenx=1, wrdst=0, wrdata=0xDEAD) -> out_wr_valid=0, out_wrdst=0, out_wrdata=0.
3. DEPTH=16, out_ready=0, 20 events -> level=16, drop_count=4. Then out_ready=1 and 1 further event -> 16 records with seq 0..15 and gap=0, followed by a record with seq 20 and gap=1.
4. Full FIFO with out_ready=1 and an event in the same cycle -> push accepted, level stays 16, drop_count unchanged.
5. in_excpt=1 (pc 0x8000_0100, priv_mode=3, wrenx=1) -> out_excpt=1, out_wr_valid=0, out_priv_mode=3. A following event with capture_en=0 -> no record produced and seq not consumed.
6. 5 records buffered, reset pulled low for 1 cycle mid-drain -> out_valid=0, level=0, drop_count=0 from the next cycle; the next event emits seq 0.
